ps2_keyboard_sim_tx: RTL and testbench

PS2_KEYBOARD_SIM_TX -- requirements
Module: ps2_keyboard_sim_tx

---
 rtl/ps2_keyboard_sim_tx.sv | 137 +++++++++++++
 tb/tb_ps2_keyboard_sim_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_sim_tx.sv
// PS/2 device-side transmitter model: queues scan-code bytes in an 8-deep FIFO
// and emits each as an 11-bit frame on device-generated ps2_clk/ps2_data.
module ps2_keyboard_sim_tx #(
    parameter int HALF_PERIOD = 50,
    parameter int GAP_CYCLES  = 100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] data_in,
    input  logic       wr,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam logic [9:0] HP_LAST  = 10'(HALF_PERIOD - 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_LOW, ST_GAP} state_t;

    logic [7:0]  r_mem [8];
    logic [2:0]  r_wp, r_rp;
    logic [3:0]  r_count;
    logic        r_overflow;

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [3:0]  r_bit;
    logic [10:0] r_frame;
    logic        r_ps2_clk, r_ps2_data, r_busy;

    logic        w_pop, w_full, w_push;
    logic [7:0]  w_head;
    logic [3:0]  w_next_bit;

    assign w_full     = (r_count == 4'd8);
    assign w_pop      = (r_state == ST_IDLE) && (r_count != 4'd0);
    // A pop frees a slot this very cycle, so a write into a full FIFO still lands.
    assign w_push     = wr && (!w_full || w_pop);
    assign w_head     = r_mem[r_rp];
    assign w_next_bit = r_bit + 4'd1;

    assign full     = w_full;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wp       <= 3'd0;
            r_rp       <= 3'd0;
            r_count    <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 3'd1;
            if (w_pop)
                r_rp <= r_rp + 3'd1;
            r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
            if (wr && !w_push)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 10'd0;
            r_bit      <= 4'd0;
            r_frame    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                    r_busy     <= 1'b0;
                    if (w_pop) begin
                        // Start bit goes out on the pop edge itself.
                        r_frame    <= {1'b1, ~^w_head, w_head, 1'b0};
                        r_bit      <= 4'd0;
                        r_cnt      <= 10'd0;
                        r_ps2_data <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == HP_LAST) begin
                        r_cnt     <= 10'd0;
                        r_ps2_clk <= 1'b0;
                        r_state   <= ST_LOW;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == HP_LAST) begin
                        r_cnt     <= 10'd0;
                        r_ps2_clk <= 1'b1;
                        if (r_bit < 4'd10) begin
                            r_bit      <= w_next_bit;
                            r_ps2_data <= r_frame[w_next_bit];
                            r_state    <= ST_SETUP;
                        end else begin
                            r_ps2_data <= 1'b1;
                            r_state    <= ST_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= 10'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_sim_tx.sv
// Directed bench for ps2_keyboard_sim_tx with a PS/2 host receiver model
// sampling ps2_data on each ps2_clk falling edge.
module tb_ps2_keyboard_sim_tx;

    localparam int HP  = 4;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       clr, wr;
    logic [7:0] data_in;
    logic       full, busy, overflow, ps2_clk, ps2_data;

    int total = 0;
    int bad   = 0;

    ps2_keyboard_sim_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .clr(clr), .data_in(data_in), .wr(wr),
        .full(full), .busy(busy), .overflow(overflow),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    always #5 clk = ~clk;

    // host receiver model
    logic [10:0] rxq[$];
    int          gapq[$];
    logic [10:0] sh;
    int          rx_cnt = 0;
    int          run    = 0;
    int          perr   = 0;
    logic        prev   = 1'b1;

    always @(negedge clk) begin
        if (clr) begin
            rx_cnt = 0;
            run    = 0;
        end else begin
            if (prev && !ps2_clk) begin
                if (rx_cnt == 0) gapq.push_back(run);
                sh[rx_cnt] = ps2_data;
                rx_cnt++;
                if (rx_cnt == 11) begin
                    rxq.push_back(sh);
                    if (sh[0] != 1'b0 || sh[10] != 1'b1 || (^sh[9:1]) != 1'b1) perr++;
                    rx_cnt = 0;
                end
            end
            if (ps2_clk) run++; else run = 0;
        end
        prev = ps2_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; wr = 1'b0; data_in = 8'h00;
        tick();
        clr = 1'b0;
        rxq.delete();
        gapq.delete();
        perr = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rxq.size() >= n) break;
            tick();
        end
        chk(tag, rxq.size(), n);
    endtask

    initial begin
        int n;
        int nfall;
        logic pc;

        // reset state
        do_reset();
        chk("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
        chk("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // single byte 0x1C: latency, busy length, frame bits
        wr = 1'b1; data_in = 8'h1C;
        tick();
        wr = 1'b0;
        chk("lat_k_busy", {31'd0, busy}, 32'd0);
        chk("lat_k_data", {31'd0, ps2_data}, 32'd1);
        tick();
        chk("lat_k1_busy", {31'd0, busy}, 32'd1);
        chk("lat_k1_data", {31'd0, ps2_data}, 32'd0);
        chk("lat_k1_clk", {31'd0, ps2_clk}, 32'd1);
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (busy) n++; else break;
        end
        chk("busy_len", n, 96);
        chk("f1c_count", rxq.size(), 1);
        if (rxq.size() >= 1) chk("f1c_bits", {21'd0, rxq[0]}, 32'h438);

        // two back-to-back frames
        do_reset();
        wr = 1'b1; data_in = 8'hF0; tick();
        data_in = 8'h1C; tick();
        wr = 1'b0;
        wait_frames("b2b_frames", 2, 1000);
        wait_idle("b2b_idle", 500);
        if (rxq.size() >= 2) begin
            chk("b2b_d0", {24'd0, rxq[0][8:1]}, 32'hF0);
            chk("b2b_p0", {31'd0, rxq[0][9]}, 32'd1);
            chk("b2b_d1", {24'd0, rxq[1][8:1]}, 32'h1C);
            chk("b2b_p1", {31'd0, rxq[1][9]}, 32'd0);
        end
        // GAP + IDLE + SETUP of ps2_clk high between the two frames
        if (gapq.size() >= 2) chk("b2b_gap", gapq[1], 13);
        else chk("b2b_gapq", gapq.size(), 2);

        // overflow: 10 consecutive writes
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; data_in = 8'h10 + 8'(i);
            tick();
        end
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_pre", {31'd0, overflow}, 32'd0);
        data_in = 8'h19;
        tick();
        wr = 1'b0;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        wait_frames("ovf_frames", 9, 3000);
        wait_idle("ovf_idle", 500);
        for (int i = 0; i < 200; i++) tick();
        chk("ovf_nframes", rxq.size(), 9);
        for (int i = 0; i < 9 && i < rxq.size(); i++)
            chk($sformatf("ovf_b%0d", i), {24'd0, rxq[i][8:1]}, 32'h10 + i);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // write into a full FIFO on the pop cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; data_in = 8'h30 + 8'(i);
            tick();
        end
        wr = 1'b0;
        chk("pop_full", {31'd0, full}, 32'd1);
        wait_idle("pop_reach_idle", 500);
        wr = 1'b1; data_in = 8'h55;
        tick();
        wr = 1'b0;
        chk("pop_ovf", {31'd0, overflow}, 32'd0);
        chk("pop_full2", {31'd0, full}, 32'd1);
        chk("pop_busy", {31'd0, busy}, 32'd1);
        wait_frames("pop_frames", 10, 3000);
        wait_idle("pop_idle", 500);
        if (rxq.size() == 10) begin
            chk("pop_b8", {24'd0, rxq[8][8:1]}, 32'h38);
            chk("pop_last", {24'd0, rxq[9][8:1]}, 32'h55);
        end

        // clr during LOW phase of data bit 3 (5th falling edge)
        do_reset();
        wr = 1'b1; data_in = 8'h1C; tick();
        wr = 1'b0;
        nfall = 0; pc = ps2_clk;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (pc && !ps2_clk) nfall++;
            pc = ps2_clk;
            if (nfall == 5) break;
        end
        chk("abort_reach", nfall, 5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_clk", {31'd0, ps2_clk}, 32'd1);
        chk("abort_data", {31'd0, ps2_data}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rxq.delete();
        nfall = 0; pc = ps2_clk;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pc && !ps2_clk) nfall++;
            pc = ps2_clk;
        end
        chk("abort_nofall", nfall, 0);
        chk("abort_norx", rxq.size(), 0);
        chk("abort_busy2", {31'd0, busy}, 32'd0);

        // host receiver loopback
        do_reset();
        wr = 1'b1; data_in = 8'h00; tick();
        data_in = 8'hFF; tick();
        data_in = 8'hA5; tick();
        wr = 1'b0;
        wait_frames("rx_frames", 3, 1500);
        wait_idle("rx_idle", 500);
        if (rxq.size() >= 3) begin
            chk("rx_b0", {24'd0, rxq[0][8:1]}, 32'h00);
            chk("rx_b1", {24'd0, rxq[1][8:1]}, 32'hFF);
            chk("rx_b2", {24'd0, rxq[2][8:1]}, 32'hA5);
        end
        chk("rx_perr", perr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
